rr_arbiter4_sel: RTL and testbench
==================================

Name: rr_arbiter4_sel

Overview:
- Four-requester round-robin arbiter that drives the select/enable inputs (A, B, enable) of the 2-to-4 decoder stage directly downstream.
- The decoder's Y0..Y3 outputs then form the one-hot grant bus.
- A bounded hold limit stops a single requester from starving the others.
- All outputs are registered, so the decoder sees glitch-free select lines.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one requester may keep the grant while another request is pending; legal range 1..15.
- CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; req[i] is requester i, level-sensitive.
- A  output  1  MSB of the granted index; registered.
- B  output  1  LSB of the granted index; registered.
- enable  output  1  1 when a grant is active; registered.
- grant_change  output  1  one-cycle pulse in the first cycle of any new grant, including a re-grant to the same requester after IDLE.

Behaviour:
- Reset: when rst is sampled high at a clock edge, the following values apply after that edge.
  - state=IDLE, enable=0, A=0, B=0, grant_change=0.
  - ptr=0, hold_cnt=0.
  - rst overrides every other input, including in mid-grant.
- Index encoding: grant index g = {A,B}, so A=g[1] and B=g[0]. The decoder therefore asserts Y(g).
- Round-robin search:
  - Order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - The first index with req=1 wins.
  - When a grant g is issued, ptr is updated to g+1 mod 4 (wraps 3 to 0).
- State IDLE:
  - enable=0; A and B hold their last values.
  - If req≠0 at an edge, go to GRANT with the search winner: enable=1, {A,B}=winner, hold_cnt=1, grant_change=1.
  - Latency is one cycle from the sampled request to enable.
- State GRANT (current index g):
  - Case a, req[g]=0 at the edge:
    - If any other request is pending, move directly to the search winner with no idle bubble: grant_change=1, hold_cnt=1.
    - Otherwise go to IDLE with enable=0.
  - Case b, req[g]=1 and hold_cnt<MAX_HOLD: keep g, increment hold_cnt, grant_change=0.
  - Case c, req[g]=1, hold_cnt=MAX_HOLD, and another request is pending:
    - Forced rotation to the search winner, which excludes g because ptr=g+1 and others pend.
    - grant_change=1, hold_cnt=1.
  - Case d, req[g]=1, hold_cnt=MAX_HOLD, and no other request is pending:
    - Keep g; hold_cnt saturates at MAX_HOLD; grant_change=0.
    - Rotation occurs on the first edge at which another request appears.
- Exclusivity: exactly one index is granted whenever enable=1; A and B never change while a grant is held.
- Simultaneous events: if req[g] drops in the same cycle as the hold limit is reached, case a applies.
- Dropped request: a request that deasserts before it is served is simply not granted; there is no memory of past requests.
- MAX_HOLD=1: the grant rotates every cycle while others request.
- grant_change is 0 in every cycle except the first cycle of a new grant.

Test Plan:
- Reset and single request:
  - Stimulus: hold rst=1 for 2 cycles, then release; req=0100.
  - Required: during reset enable=0, A=0, B=0. One cycle after the req edge, enable=1, {A,B}=10, and grant_change=1 for one cycle.
- Round-robin fairness:
  - Stimulus: after reset, req=1111 held, with MAX_HOLD=8 and each requester dropping its req after 2 granted cycles, then re-raising it.
  - Required: grant order is 0,1,2,3,0 and A,B step 00,01,10,11,00. No idle cycle between grants.
- Hold limit:
  - Stimulus: req=0001 steady; at cycle 3 also raise req[2], giving req=0101.
  - Required: index 0 is held for exactly 8 cycles. Then {A,B}=10 with a grant_change pulse, and ptr wraps correctly.
- Saturation with a lone requester:
  - Stimulus: req=1000 for 20 cycles.
  - Required: {A,B}=11 and enable=1 throughout, grant_change only in the first cycle. Raising req[0] at cycle 20 moves the grant to 00 on the next edge.
- Release to IDLE:
  - Stimulus: grant held on index 1; req drops to 0000.
  - Required: enable=0 after the next edge and A,B unchanged. When req=0010 is re-raised, the re-grant {A,B}=01 comes with a grant_change pulse.
- Reset mid-grant:
  - Stimulus: assert rst for one cycle while index 3 is granted and req=1111.
  - Required: after that edge enable=0, A=0, B=0. After release, the next grant is index 0, because ptr was reset to 0.

Source files
------------

// File: rtl/rr_arbiter4_sel.sv
// Four-requester round-robin arbiter driving the A/B/enable selects of a
// 2-to-4 decoder, with a bounded hold limit; all outputs registered.
module rr_arbiter4_sel #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic       A,
    output logic       B,
    output logic       enable,
    output logic       grant_change
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    state_t           state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic [1:0]       cur;
    logic [1:0]       winner;
    logic [3:0]       cur_mask;
    logic             others;
    logic             cur_req;
    logic             at_limit;

    assign cur      = {A, B};
    assign cur_mask = 4'b0001 << cur;
    assign others   = |(req & ~cur_mask);
    assign cur_req  = |(req & cur_mask);
    assign at_limit = (hold_cnt >= HOLD_MAX);

    // Scan from the farthest slot back to ptr so the nearest requester wins.
    always_comb begin
        winner = ptr;
        for (int i = 3; i >= 0; i--) begin
            if (req[ptr + 2'(i)]) begin
                winner = ptr + 2'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            enable       <= 1'b0;
            A            <= 1'b0;
            B            <= 1'b0;
            grant_change <= 1'b0;
            ptr          <= 2'd0;
            hold_cnt     <= '0;
        end else begin
            grant_change <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state        <= GRANT;
                        enable       <= 1'b1;
                        {A, B}       <= winner;
                        ptr          <= winner + 2'd1;
                        hold_cnt     <= CNT_W'(1);
                        grant_change <= 1'b1;
                    end
                end
                GRANT: begin
                    unique case (1'b1)
                        (!cur_req && others),
                        (cur_req && at_limit && others): begin
                            {A, B}       <= winner;
                            ptr          <= winner + 2'd1;
                            hold_cnt     <= CNT_W'(1);
                            grant_change <= 1'b1;
                        end
                        (!cur_req && !others): begin
                            state  <= IDLE;
                            enable <= 1'b0;
                        end
                        (cur_req && !at_limit): begin
                            hold_cnt <= hold_cnt + CNT_W'(1);
                        end
                        default: begin
                            hold_cnt <= HOLD_MAX;
                        end
                    endcase
                end
                default: begin
                    state  <= IDLE;
                    enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter4_sel.sv
// Scoreboard bench for rr_arbiter4_sel: directed scenarios plus random
// traffic, checked against a cycle-level behavioural model.
module tb_rr_arbiter4_sel;

    localparam int MAX_HOLD = 8;

    typedef struct packed {
        logic en;
        logic a;
        logic b;
        logic gc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       A;
    logic       B;
    logic       enable;
    logic       grant_change;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   cyc;

    // Reference model state
    bit m_en;
    bit m_gc;
    int m_g;
    int m_ptr;
    int m_held;

    rr_arbiter4_sel #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .A           (A),
        .B           (B),
        .enable      (enable),
        .grant_change(grant_change)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return p;
    endfunction

    function automatic void model_issue(input logic [3:0] r);
        m_g    = pick(r, m_ptr);
        m_ptr  = (m_g + 1) % 4;
        m_en   = 1'b1;
        m_held = 1;
        m_gc   = 1'b1;
    endfunction

    function automatic void model_step(input logic r_rst, input logic [3:0] r);
        logic [3:0] rest;
        if (r_rst) begin
            m_en = 0; m_gc = 0; m_g = 0; m_ptr = 0; m_held = 0;
            return;
        end
        m_gc = 1'b0;
        rest = r;
        rest[m_g] = 1'b0;
        if (!m_en) begin
            if (r != 4'd0) model_issue(r);
        end else if (!r[m_g]) begin
            if (rest != 4'd0) model_issue(r);
            else m_en = 1'b0;
        end else if (m_held < MAX_HOLD || rest == 4'd0) begin
            m_held++;
        end else begin
            model_issue(r);
        end
    endfunction

    task automatic drive(input logic r_rst, input logic [3:0] r);
        exp_t e;
        @(negedge clk);
        rst = r_rst;
        req = r;
        @(posedge clk);
        model_step(r_rst, r);
        e.en = m_en;
        e.a  = m_g[1];
        e.b  = m_g[0];
        e.gc = m_gc;
        exp_q.push_back(e);
    endtask

    task automatic drive_n(input int n, input logic [3:0] r);
        for (int i = 0; i < n; i++) drive(1'b0, r);
    endtask

    // Monitor: every cycle after the edge the DUT presents its outputs
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {enable, A, B, grant_change};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs cyc %0d: got en=%b AB=%b%b gc=%b, expected en=%b AB=%b%b gc=%b",
                             cyc, got.en, got.a, got.b, got.gc, e.en, e.a, e.b, e.gc);
                end
            end
        end
    end

    initial begin
        logic [3:0] r;
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        req    = 4'd0;
        m_en = 0; m_gc = 0; m_g = 0; m_ptr = 0; m_held = 0;

        // Reset, then single request on index 2
        drive(1'b1, 4'b0000);
        drive(1'b1, 4'b0000);
        drive_n(4, 4'b0100);
        drive_n(2, 4'b0000);

        // Fairness: everyone requests, each drops after two granted cycles
        drive(1'b1, 4'b0000);
        for (int i = 0; i < 14; i++) begin
            r = 4'b1111;
            if (m_en && m_held >= 2) r[m_g] = 1'b0;
            drive(1'b0, r);
        end

        // Hold limit: lone 0, then 2 joins
        drive(1'b1, 4'b0000);
        drive_n(3, 4'b0001);
        drive_n(12, 4'b0101);

        // Saturation with a lone requester, then 0 joins
        drive(1'b1, 4'b0000);
        drive_n(20, 4'b1000);
        drive_n(3, 4'b1001);

        // Release to IDLE and re-grant of the same index
        drive_n(3, 4'b0010);
        drive_n(3, 4'b0000);
        drive_n(3, 4'b0010);

        // Reset mid-grant on index 3
        drive_n(4, 4'b1000);
        drive(1'b1, 4'b1111);
        drive_n(4, 4'b1111);

        // Random traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            r = 4'($urandom);
            if ($urandom_range(0, 3) == 0) r = 4'b0001 << $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) r = 4'd0;
            drive(($urandom_range(0, 99) == 0), r);
        end

        repeat (2) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected responses never compared, required 0",
                     exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
